// File: rtl/rv32i_dxw_datapath.sv
// Decode/execute/write-back datapath for the multi-cycle RV32I core, with a private word-wide data memory.
// Optional RV32M_EN adds MUL/MULH/MULHSU/MULHU; without it every funct7=0000001 OP is a NOP.
module rv32i_dxw_datapath #(
    parameter int DMEM_DEPTH = 1024
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [31:0] i_instruction,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1_val,
    input  logic [31:0] i_rs2_val,
    input  logic        i_exec_en,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic [31:0] o_jump_dest,
    output logic        o_write_enable,
    output logic [31:0] o_write_data
);
    localparam int AW = $clog2(DMEM_DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [6:0]    w_opcode;
    logic [2:0]    w_funct3;
    logic [6:0]    w_funct7;
    logic [31:0]   w_imm_i;
    logic [31:0]   w_imm_s;
    logic [31:0]   w_imm_b;
    logic [31:0]   w_imm_u;
    logic [31:0]   w_imm_j;
    logic [31:0]   w_pc_next;
    logic [31:0]   w_alu_b;
    logic          w_alu_sub;
    logic [31:0]   w_alu;
    logic          w_taken;
    logic          w_writes;
    logic          w_load;
    logic          w_store;
    logic [31:0]   w_result;
    logic [31:0]   w_jump_dest;
    logic [31:0]   w_mem_off;
    logic [AW-1:0] w_mem_idx;

    logic [31:0] r_mem [DMEM_DEPTH] = '{default: '0};
    logic        r_write_enable;
    logic [31:0] r_write_data;

    assign w_opcode = i_instruction[6:0];
    assign w_funct3 = i_instruction[14:12];
    assign w_funct7 = i_instruction[31:25];
    assign o_rs1    = i_instruction[19:15];
    assign o_rs2    = i_instruction[24:20];
    assign o_rd     = i_instruction[11:7];

    assign w_imm_i = {{20{i_instruction[31]}}, i_instruction[31:20]};
    assign w_imm_s = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
    assign w_imm_b = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                      i_instruction[30:25], i_instruction[11:8], 1'b0};
    assign w_imm_u = {i_instruction[31:12], 12'b0};
    assign w_imm_j = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                      i_instruction[20], i_instruction[30:21], 1'b0};

    assign w_pc_next = i_pc + 32'd1;

    // Memory wraps modulo DMEM_DEPTH words; the cast drops byte offset and high address bits.
    assign w_mem_off = (w_opcode == OPC_STORE) ? w_imm_s : w_imm_i;
    assign w_mem_idx = AW'((i_rs1_val + w_mem_off) >> 2);

    assign w_alu_b   = (w_opcode == OPC_OP) ? i_rs2_val : w_imm_i;
    assign w_alu_sub = (w_opcode == OPC_OP) && w_funct7[5];

    always_comb begin
        w_alu = '0;
        case (w_funct3)
            3'b000:  w_alu = w_alu_sub ? (i_rs1_val - w_alu_b) : (i_rs1_val + w_alu_b);
            3'b001:  w_alu = i_rs1_val << w_alu_b[4:0];
            3'b010:  w_alu = {31'b0, $signed(i_rs1_val) < $signed(w_alu_b)};
            3'b011:  w_alu = {31'b0, i_rs1_val < w_alu_b};
            3'b100:  w_alu = i_rs1_val ^ w_alu_b;
            3'b101:  w_alu = w_funct7[5] ? 32'($signed(i_rs1_val) >>> w_alu_b[4:0])
                                         : (i_rs1_val >> w_alu_b[4:0]);
            3'b110:  w_alu = i_rs1_val | w_alu_b;
            default: w_alu = i_rs1_val & w_alu_b;
        endcase
    end

`ifdef RV32M_EN
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;
    logic [31:0] w_mul_res;

    // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
    assign w_mul_a = {{32{(w_funct3 == 3'b001 || w_funct3 == 3'b010) && i_rs1_val[31]}}, i_rs1_val};
    assign w_mul_b = {{32{(w_funct3 == 3'b001) && i_rs2_val[31]}}, i_rs2_val};
    assign w_prod  = w_mul_a * w_mul_b;
    assign w_mul_res = (w_funct3 == 3'b000) ? w_prod[31:0] : w_prod[63:32];
`endif

    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_taken = (i_rs1_val == i_rs2_val);
            3'b001:  w_taken = (i_rs1_val != i_rs2_val);
            3'b100:  w_taken = ($signed(i_rs1_val) < $signed(i_rs2_val));
            3'b101:  w_taken = ($signed(i_rs1_val) >= $signed(i_rs2_val));
            3'b110:  w_taken = (i_rs1_val < i_rs2_val);
            3'b111:  w_taken = (i_rs1_val >= i_rs2_val);
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_writes    = 1'b0;
        w_load      = 1'b0;
        w_store     = 1'b0;
        w_result    = w_alu;
        w_jump_dest = w_pc_next;
        case (w_opcode)
            OPC_LUI: begin
                w_writes = 1'b1;
                w_result = w_imm_u;
            end
            OPC_AUIPC: begin
                w_writes = 1'b1;
                w_result = (i_pc << 2) + w_imm_u;
            end
            OPC_JAL: begin
                w_writes    = 1'b1;
                w_result    = w_pc_next;
                w_jump_dest = i_pc + 32'($signed(w_imm_j) >>> 2);
            end
            OPC_JALR: begin
                if (w_funct3 == 3'b000) begin
                    w_writes    = 1'b1;
                    w_result    = w_pc_next;
                    w_jump_dest = i_rs1_val + 32'($signed(w_imm_i) >>> 2);
                end
            end
            OPC_BRANCH: begin
                if (w_taken) begin
                    w_jump_dest = i_pc + 32'($signed(w_imm_b) >>> 2);
                end
            end
            OPC_LOAD: begin
                if (w_funct3 == 3'b010) begin
                    w_writes = 1'b1;
                    w_load   = 1'b1;
                end
            end
            OPC_STORE: begin
                w_store = (w_funct3 == 3'b010);
            end
            OPC_OP_IMM: begin
                if (w_funct3 == 3'b001) begin
                    w_writes = (w_funct7 == 7'b0000000);
                end else if (w_funct3 == 3'b101) begin
                    w_writes = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
                end else begin
                    w_writes = 1'b1;
                end
            end
            OPC_OP: begin
                if (w_funct7 == 7'b0000000) begin
                    w_writes = 1'b1;
                end else if (w_funct7 == 7'b0100000 &&
                             (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
                    w_writes = 1'b1;
`ifdef RV32M_EN
                end else if (w_funct7 == 7'b0000001 && !w_funct3[2]) begin
                    w_writes = 1'b1;
                    w_result = w_mul_res;
`endif
                end
            end
            default: begin
                w_writes = 1'b0;
            end
        endcase
    end

    assign o_jump_dest = w_jump_dest;

    always_ff @(posedge i_clk) begin
        if (!i_rstn && i_exec_en && w_store) begin
            r_mem[w_mem_idx] <= i_rs2_val;
        end
    end

    // Load reads the pre-edge memory word, so a same-edge store never bypasses into it.
    always_ff @(posedge i_clk) begin
        if (i_rstn) begin
            r_write_enable <= 1'b0;
            r_write_data   <= '0;
        end else if (i_exec_en) begin
            r_write_enable <= w_writes && (o_rd != 5'd0);
            r_write_data   <= w_load ? r_mem[w_mem_idx] : w_result;
        end
    end

    assign o_write_enable = r_write_enable;
    assign o_write_data   = r_write_data;
endmodule

// File: tb/tb_rv32i_dxw_datapath.sv
// Directed self-checking bench for rv32i_dxw_datapath; inputs change and outputs are sampled on the falling edge.
// The multiply test follows RV32M_EN so one bench covers both builds.
module tb_rv32i_dxw_datapath;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        exec_en;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] jump_dest;
    logic        write_enable;
    logic [31:0] write_data;

    int n_cmp = 0;
    int n_err = 0;

    rv32i_dxw_datapath #(.DMEM_DEPTH(1024)) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_instruction  (instr),
        .i_pc           (pc),
        .i_rs1_val      (rs1_val),
        .i_rs2_val      (rs2_val),
        .i_exec_en      (exec_en),
        .o_rs1          (rs1),
        .o_rs2          (rs2),
        .o_rd           (rd),
        .o_jump_dest    (jump_dest),
        .o_write_enable (write_enable),
        .o_write_data   (write_data)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        instr   = ins;
        pc      = p;
        rs1_val = a;
        rs2_val = b;
    endtask

    // Called at a falling edge; returns at the falling edge after the strobed rising edge.
    task automatic strobe();
        exec_en = 1'b1;
        @(negedge clk);
        exec_en = 1'b0;
    endtask

    task automatic test_reset();
        rstn    = 1'b1;
        exec_en = 1'b1;
        drive(32'h00112E23, 32'd0, 32'hFFFFFFE4, 32'hDEADBEEF);
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", write_enable); end
        n_cmp++; if (write_data !== 32'd0) begin n_err++; $display("FAIL reset_wd: got %h want 0", write_data); end
        rstn    = 1'b0;
        exec_en = 1'b0;
        drive(32'h01C12083, 32'd0, 32'hFFFFFFE4, 32'd0);
        @(negedge clk);
        strobe();
        n_cmp++; if (write_data !== 32'd0) begin n_err++; $display("FAIL reset_mem_kept: got %h want 0", write_data); end
        n_cmp++; if (write_enable !== 1'b1) begin n_err++; $display("FAIL reset_lw_we: got %b want 1", write_enable); end
    endtask

    task automatic test_addi();
        drive(32'hFE010113, 32'd1, 32'd500, 32'd0);
        #1;
        n_cmp++; if (rs1 !== 5'd2) begin n_err++; $display("FAIL addi_rs1: got %0d want 2", rs1); end
        n_cmp++; if (rd !== 5'd2) begin n_err++; $display("FAIL addi_rd: got %0d want 2", rd); end
        n_cmp++; if (jump_dest !== 32'd2) begin n_err++; $display("FAIL addi_jd: got %0d want 2", jump_dest); end
        strobe();
        n_cmp++; if (write_enable !== 1'b1) begin n_err++; $display("FAIL addi_we: got %b want 1", write_enable); end
        n_cmp++; if (write_data !== 32'd468) begin n_err++; $display("FAIL addi_wd: got %0d want 468", write_data); end
    endtask

    task automatic test_jal();
        drive(32'h074000EF, 32'd0, 32'd0, 32'd0);
        #1;
        n_cmp++; if (jump_dest !== 32'd29) begin n_err++; $display("FAIL jal_jd: got %0d want 29", jump_dest); end
        n_cmp++; if (rd !== 5'd1) begin n_err++; $display("FAIL jal_rd: got %0d want 1", rd); end
        strobe();
        n_cmp++; if (write_enable !== 1'b1) begin n_err++; $display("FAIL jal_we: got %b want 1", write_enable); end
        n_cmp++; if (write_data !== 32'd1) begin n_err++; $display("FAIL jal_wd: got %0d want 1", write_data); end
    endtask

    task automatic test_store_load();
        drive(32'h00112E23, 32'd2, 32'd468, 32'd7);
        strobe();
        n_cmp++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL sw_we: got %b want 0", write_enable); end
        drive(32'h01C12083, 32'd3, 32'd468, 32'd0);
        strobe();
        n_cmp++; if (write_data !== 32'd7) begin n_err++; $display("FAIL lw_wd: got %0d want 7", write_data); end
        n_cmp++; if (write_enable !== 1'b1) begin n_err++; $display("FAIL lw_we: got %b want 1", write_enable); end
        // Address 4592 wraps to the same word as 496.
        drive(32'h01C12083, 32'd4, 32'd4564, 32'd0);
        strobe();
        n_cmp++; if (write_data !== 32'd7) begin n_err++; $display("FAIL lw_wrap: got %0d want 7", write_data); end
        // Idle cycles with a different instruction must leave the result alone.
        drive(32'hFE010113, 32'd5, 32'd900, 32'd0);
        repeat (3) @(negedge clk);
        n_cmp++; if (write_data !== 32'd7) begin n_err++; $display("FAIL hold_wd: got %0d want 7", write_data); end
        // Reset with a strobed store to the same word: result cleared, memory untouched.
        rstn    = 1'b1;
        exec_en = 1'b1;
        drive(32'h00112E23, 32'd6, 32'd468, 32'd99);
        @(negedge clk);
        @(negedge clk);
        rstn    = 1'b0;
        exec_en = 1'b0;
        n_cmp++; if (write_data !== 32'd0) begin n_err++; $display("FAIL midrst_wd: got %0d want 0", write_data); end
        drive(32'h01C12083, 32'd7, 32'd468, 32'd0);
        strobe();
        n_cmp++; if (write_data !== 32'd7) begin n_err++; $display("FAIL rst_nostore: got %0d want 7", write_data); end
    endtask

    task automatic test_branch();
        drive(32'h00E7C663, 32'd9, 32'd1, 32'd3);
        #1;
        n_cmp++; if (jump_dest !== 32'd12) begin n_err++; $display("FAIL blt_taken: got %0d want 12", jump_dest); end
        drive(32'h00E7C663, 32'd9, 32'd3, 32'd1);
        #1;
        n_cmp++; if (jump_dest !== 32'd10) begin n_err++; $display("FAIL blt_not: got %0d want 10", jump_dest); end
        drive(32'h00E7C663, 32'd9, 32'hFFFFFFFF, 32'd1);
        #1;
        n_cmp++; if (jump_dest !== 32'd12) begin n_err++; $display("FAIL blt_signed: got %0d want 12", jump_dest); end
        strobe();
        n_cmp++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL blt_we: got %b want 0", write_enable); end
    endtask

    task automatic test_jalr();
        drive(32'h00008067, 32'd20, 32'd16, 32'd0);
        #1;
        n_cmp++; if (jump_dest !== 32'd16) begin n_err++; $display("FAIL ret_jd: got %0d want 16", jump_dest); end
        strobe();
        n_cmp++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL ret_we: got %b want 0", write_enable); end
        drive(32'h008500E7, 32'd5, 32'd16, 32'd0);
        #1;
        n_cmp++; if (jump_dest !== 32'd18) begin n_err++; $display("FAIL jalr_jd: got %0d want 18", jump_dest); end
        strobe();
        n_cmp++; if (write_data !== 32'd6) begin n_err++; $display("FAIL jalr_link: got %0d want 6", write_data); end
        n_cmp++; if (write_enable !== 1'b1) begin n_err++; $display("FAIL jalr_we: got %b want 1", write_enable); end
    endtask

    task automatic test_alu();
        drive(32'h12345537, 32'd0, 32'd0, 32'd0);
        strobe();
        n_cmp++; if (write_data !== 32'h12345000) begin n_err++; $display("FAIL lui: got %h want 12345000", write_data); end
        drive(32'h00001517, 32'd3, 32'd0, 32'd0);
        strobe();
        n_cmp++; if (write_data !== 32'h0000100C) begin n_err++; $display("FAIL auipc: got %h want 0000100c", write_data); end
        drive(32'h40C58533, 32'd0, 32'd5, 32'd7);
        strobe();
        n_cmp++; if (write_data !== 32'hFFFFFFFE) begin n_err++; $display("FAIL sub: got %h want fffffffe", write_data); end
        drive(32'h4045D513, 32'd0, 32'h80000000, 32'd0);
        strobe();
        n_cmp++; if (write_data !== 32'hF8000000) begin n_err++; $display("FAIL srai: got %h want f8000000", write_data); end
        drive(32'h00C5B533, 32'd0, 32'd1, 32'hFFFFFFFF);
        strobe();
        n_cmp++; if (write_data !== 32'd1) begin n_err++; $display("FAIL sltu: got %h want 1", write_data); end
        drive(32'h00C5A533, 32'd0, 32'd1, 32'hFFFFFFFF);
        strobe();
        n_cmp++; if (write_data !== 32'd0) begin n_err++; $display("FAIL slt: got %h want 0", write_data); end
        n_cmp++; if (write_enable !== 1'b1) begin n_err++; $display("FAIL slt_we: got %b want 1", write_enable); end
    endtask

    task automatic test_nop();
        drive(32'h40459513, 32'd40, 32'd3, 32'd0);
        #1;
        n_cmp++; if (jump_dest !== 32'd41) begin n_err++; $display("FAIL nop_jd: got %0d want 41", jump_dest); end
        strobe();
        n_cmp++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL nop_we: got %b want 0", write_enable); end
    endtask

    task automatic test_mul();
        drive(32'h02B50533, 32'd8, 32'd6, 32'd7);
        #1;
        n_cmp++; if (jump_dest !== 32'd9) begin n_err++; $display("FAIL mul_jd: got %0d want 9", jump_dest); end
        strobe();
`ifdef RV32M_EN
        n_cmp++; if (write_data !== 32'd42) begin n_err++; $display("FAIL mul_wd: got %0d want 42", write_data); end
        n_cmp++; if (write_enable !== 1'b1) begin n_err++; $display("FAIL mul_we: got %b want 1", write_enable); end
        drive(32'h02B53533, 32'd8, 32'hFFFFFFFF, 32'hFFFFFFFF);
        strobe();
        n_cmp++; if (write_data !== 32'hFFFFFFFE) begin n_err++; $display("FAIL mulhu_wd: got %h want fffffffe", write_data); end
`else
        n_cmp++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL mul_nop_we: got %b want 0", write_enable); end
`endif
    endtask

    initial begin
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        rstn    = 1'b1;
        exec_en = 1'b0;
        test_reset();
        test_addi();
        test_jal();
        test_store_load();
        test_branch();
        test_jalr();
        test_alu();
        test_nop();
        test_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
